// File: rtl/spi_regbank_slave.sv
// spi_regbank_slave
//   SPI slave (all four CPOL/CPHA modes) in front of a byte-wide register bank.
//   Each frame is 16 bits, MSB first: a command byte {wr, space, 2'bx, addr[3:0]}
//   followed by a data byte. Writes land in the config bank. Reads return either
//   a config register or a status register.
//   SPI pins arrive already synchronized and are oversampled with clk.
//   Optional burst mode: define SPI_REGBANK_AUTOINC_EN to auto-increment the
//   address after every data byte until chip select rises.
module spi_regbank_slave #(
   parameter int NUM_CFG    = 8,   // 1..16
   parameter int NUM_STATUS = 8,   // 1..16
   parameter int REG_WIDTH  = 8    // frames are byte-oriented, so this must stay 8
) (
   input  logic                            clk,
   input  logic                            rstb,
   input  logic                            ena,
   input  logic [1:0]                      mode,
   input  logic                            spi_cs_n,
   input  logic                            spi_clk,
   input  logic                            spi_mosi,
   output logic                            spi_miso,
   output logic [NUM_CFG*REG_WIDTH-1:0]    config_regs,
   input  logic [NUM_STATUS*REG_WIDTH-1:0] status_regs
);

   localparam logic [4:0] CMD_BITS   = 5'd8;
   localparam logic [4:0] FRAME_BITS = 5'd16;

   logic       clk_d_q;
   logic [4:0] cnt_q, cnt_d;
   logic [7:0] rx_q, rx_d, rx_next;
   logic [7:0] cmd_q, cmd_d;
   logic [3:0] addr_q, addr_d;
   logic [7:0] tx_q, tx_d;
   logic       skip_q, skip_d;
   logic       miso_q, miso_d;
   logic [7:0] cfg_q [NUM_CFG];

   logic       wr_en;
   logic [3:0] wr_addr;
   logic [7:0] wr_data;
   logic       rise, fall, sample_edge, shift_edge;

   // Register read mux. An address beyond the populated bank reads as 0x00.
   function automatic logic [7:0] read_reg(input logic space, input logic [3:0] addr);
      logic [7:0] val;
      val = '0;
      if (space) begin
         for (int i = 0; i < NUM_STATUS; i++)
            if (addr == 4'(i)) val = status_regs[i*REG_WIDTH +: 8];
      end else begin
         for (int i = 0; i < NUM_CFG; i++)
            if (addr == 4'(i)) val = cfg_q[i];
      end
      return val;
   endfunction

   // Edge detection on the oversampled SPI clock; mode picks the sample and shift edges.
   always_comb begin
      rise        = spi_clk & ~clk_d_q;
      fall        = ~spi_clk & clk_d_q;
      sample_edge = ~spi_cs_n & ((mode[1] == mode[0]) ? rise : fall);
      shift_edge  = ~spi_cs_n & ((mode[1] == mode[0]) ? fall : rise);
   end

   // Frame sequencing: bit count, command latch, read load, write commit and MISO shift.
   always_comb begin
      // NOTE: every signal driven here gets a default first so no path can infer a latch.
      cnt_d   = cnt_q;
      rx_d    = rx_q;
      cmd_d   = cmd_q;
      addr_d  = addr_q;
      tx_d    = tx_q;
      skip_d  = skip_q;
      rx_next = {rx_q[6:0], spi_mosi};
      wr_en   = 1'b0;
      wr_addr = addr_q;
      wr_data = rx_next;

      if (spi_cs_n) begin
         // Idle or aborted frame: rewind and drop any pending read data.
         cnt_d  = '0;
         tx_d   = '0;
         skip_d = 1'b0;
      end else if (sample_edge && (cnt_q < FRAME_BITS)) begin
         rx_d  = rx_next;
         cnt_d = cnt_q + 5'd1;
         if (cnt_q == CMD_BITS - 5'd1) begin
            // Command byte complete: latch it and preload the addressed register.
            cmd_d  = rx_next;
            addr_d = rx_next[3:0];
            tx_d   = read_reg(rx_next[6], rx_next[3:0]);
            skip_d = 1'b1;
         end else if (cnt_q == FRAME_BITS - 5'd1) begin
            // Data byte complete: commit only to an existing config register.
            wr_en = cmd_q[7] & ~cmd_q[6] & (int'(addr_q) < NUM_CFG);
`ifdef SPI_REGBANK_AUTOINC_EN
            addr_d = addr_q + 4'd1;
            cnt_d  = CMD_BITS;
            tx_d   = read_reg(cmd_q[6], addr_q + 4'd1);
            skip_d = 1'b1;
`endif
         end
      end else if (shift_edge) begin
         // The first shift edge after a load would discard bit 7 before it is sampled.
         if (skip_q) skip_d = 1'b0;
         else        tx_d   = {tx_q[6:0], 1'b0};
      end

      miso_d = ((cnt_d >= CMD_BITS) && (cnt_d < FRAME_BITS)) ? tx_d[7] : 1'b0;
   end

   // Protocol state; everything holds while ena is low.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         clk_d_q <= 1'b0;
         cnt_q   <= '0;
         rx_q    <= '0;
         cmd_q   <= '0;
         addr_q  <= '0;
         tx_q    <= '0;
         skip_q  <= 1'b0;
         miso_q  <= 1'b0;
      end else if (ena) begin
         // NOTE: sequential state uses non-blocking assignment so all flops update together.
         clk_d_q <= spi_clk;
         cnt_q   <= cnt_d;
         rx_q    <= rx_d;
         cmd_q   <= cmd_d;
         addr_q  <= addr_d;
         tx_q    <= tx_d;
         skip_q  <= skip_d;
         miso_q  <= miso_d;
      end
   end

   // Config register bank written on frame commit.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         // NOTE: the bank is plain flops driving the ALU, so it is reset like any other state.
         for (int i = 0; i < NUM_CFG; i++) cfg_q[i] <= '0;
      end else if (ena && wr_en) begin
         for (int i = 0; i < NUM_CFG; i++)
            if (wr_addr == 4'(i)) cfg_q[i] <= wr_data;
      end
   end

   for (genvar g = 0; g < NUM_CFG; g++) begin : g_cfg_out
      assign config_regs[g*REG_WIDTH +: REG_WIDTH] = cfg_q[g];
   end

   assign spi_miso = miso_q;

endmodule

// File: tb/tb_spi_regbank_slave.sv
// tb_spi_regbank_slave
//   Drives SPI frames in all four modes and compares MISO bits and the config bus
//   against a byte-level register model of the bank.
module tb_spi_regbank_slave;

   localparam int NUM_CFG    = 8;
   localparam int NUM_STATUS = 8;
`ifdef SPI_REGBANK_AUTOINC_EN
   localparam bit AUTOINC = 1'b1;
`else
   localparam bit AUTOINC = 1'b0;
`endif

   logic                      clk = 1'b0;
   logic                      rstb = 1'b0;
   logic                      ena = 1'b1;
   logic [1:0]                mode = 2'd0;
   logic                      spi_cs_n = 1'b1;
   logic                      spi_clk = 1'b0;
   logic                      spi_mosi = 1'b0;
   logic                      spi_miso;
   logic [NUM_CFG*8-1:0]      config_regs;
   logic [NUM_STATUS*8-1:0]   status_regs = '0;

   always #5 clk = ~clk;

   spi_regbank_slave #(
      .NUM_CFG    (NUM_CFG),
      .NUM_STATUS (NUM_STATUS),
      .REG_WIDTH  (8)
   ) dut (
      .clk         (clk),
      .rstb        (rstb),
      .ena         (ena),
      .mode        (mode),
      .spi_cs_n    (spi_cs_n),
      .spi_clk     (spi_clk),
      .spi_mosi    (spi_mosi),
      .spi_miso    (spi_miso),
      .config_regs (config_regs),
      .status_regs (status_regs)
   );

   int         total = 0;
   int         bad   = 0;
   logic [7:0] cfg_m [16];
   logic       cmp_cfg = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] cfg_flat();
      logic [63:0] v;
      v = '0;
      for (int i = 0; i < NUM_CFG; i++) v[i*8 +: 8] = cfg_m[i];
      return v;
   endfunction

   function automatic logic [7:0] model_read(input logic space, input logic [3:0] a);
      int ai;
      ai = int'(a);
      if (space) return (ai < NUM_STATUS) ? status_regs[ai*8 +: 8] : 8'h00;
      return (ai < NUM_CFG) ? cfg_m[ai] : 8'h00;
   endfunction

   // Config bus compare against the model whenever the bus is idle and settled.
   always @(negedge clk) begin
      if (cmp_cfg) check("cfg_bus", config_regs, cfg_flat());
   end

   task automatic half();
      repeat (5) @(negedge clk);
   endtask

   // One bit; mi is MISO as seen just before the sample edge.
   task automatic send_bit(input logic cpha, input logic b, output logic mi);
      if (!cpha) begin
         spi_mosi = b;
         half();
         mi = spi_miso;
         spi_clk = ~spi_clk;
         half();
         spi_clk = ~spi_clk;
      end else begin
         spi_clk = ~spi_clk;
         spi_mosi = b;
         half();
         mi = spi_miso;
         spi_clk = ~spi_clk;
         half();
      end
   endtask

   task automatic begin_frame(input logic [1:0] m);
      cmp_cfg = 1'b0;
      mode = m;
      spi_clk = m[1];
      repeat (3) @(negedge clk);
      spi_cs_n = 1'b0;
      half();
   endtask

   task automatic end_frame();
      half();
      spi_cs_n = 1'b1;
      repeat (3) @(negedge clk);
      cmp_cfg = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   // Full or partial frame of nbits (up to 32); rd0 is the first data byte seen on MISO.
   task automatic frame(input logic [1:0] m, input logic [7:0] cmd,
                        input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                        input int nbits, input bit glitch, output logic [7:0] rd0);
      logic [31:0] tx;
      logic [7:0]  exp_byte;
      logic [3:0]  a;
      logic        mi;
      int          j;
      tx = {cmd, d0, d1, d2};
      a = cmd[3:0];
      exp_byte = 8'h00;
      rd0 = 8'h00;
      begin_frame(m);
      for (int k = 1; k <= nbits; k++) begin
         if (k >= 9 && ((k - 9) % 8) == 0) begin
            j = (k - 9) / 8;
            exp_byte = (j == 0 || AUTOINC) ? model_read(cmd[6], a) : 8'h00;
         end
         if (glitch && k == 12) begin
            // A full SPI clock pulse while disabled must leave no trace.
            ena = 1'b0;
            repeat (2) @(negedge clk);
            spi_clk = ~spi_clk;
            repeat (3) @(negedge clk);
            spi_clk = ~spi_clk;
            repeat (3) @(negedge clk);
            ena = 1'b1;
            repeat (2) @(negedge clk);
         end
         send_bit(m[0], tx[32-k], mi);
         if (k <= 8) check("miso_cmd_phase", mi, 1'b0);
         else        check("miso_data_bit", mi, exp_byte[7 - ((k - 9) % 8)]);
         if (k >= 9 && k <= 16) rd0 = {rd0[6:0], mi};
         if (k >= 16 && ((k - 16) % 8) == 0) begin
            j = (k - 16) / 8;
            if (j == 0 || AUTOINC) begin
               if (cmd[7] && !cmd[6] && int'(a) < NUM_CFG) cfg_m[a] = tx[23 - 8*j -: 8];
               a = a + 4'd1;
            end
         end
      end
      end_frame();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [7:0] rd;
      logic       mi;
      int         nb [6];
      nb = '{16, 16, 16, 12, 24, 32};
      for (int i = 0; i < 16; i++) cfg_m[i] = 8'h00;

      // Reset state.
      repeat (3) @(negedge clk);
      check("reset_cfg", config_regs, 64'h0);
      check("reset_miso", spi_miso, 1'b0);
      rstb = 1'b1;
      repeat (3) @(negedge clk);
      cmp_cfg = 1'b1;

      // Mode 0 write 0x5A to config addr 2.
      frame(2'd0, 8'h82, 8'h5A, 8'h00, 8'h00, 16, 1'b0, rd);
      check("plan_write_5a", config_regs, 64'h0000_0000_005A_0000);

      // Mode 3 read of status register 4.
      status_regs = 64'h0000_00C4_0000_0000;
      frame(2'd3, 8'h44, 8'h00, 8'h00, 8'h00, 16, 1'b0, rd);
      check("plan_read_c4", rd, 8'hC4);
      check("plan_read_cfg_same", config_regs, 64'h0000_0000_005A_0000);

      // Modes 1 and 2 write/readback of addr 0.
      frame(2'd1, 8'h80, 8'hA5, 8'h00, 8'h00, 16, 1'b0, rd);
      frame(2'd1, 8'h00, 8'h00, 8'h00, 8'h00, 16, 1'b0, rd);
      check("plan_mode1_rb", rd, 8'hA5);
      frame(2'd0, 8'h80, 8'h00, 8'h00, 8'h00, 16, 1'b0, rd);
      frame(2'd2, 8'h80, 8'hA5, 8'h00, 8'h00, 16, 1'b0, rd);
      frame(2'd2, 8'h00, 8'h00, 8'h00, 8'h00, 16, 1'b0, rd);
      check("plan_mode2_rb", rd, 8'hA5);

      // Dropped writes: status space and out-of-range config address.
      frame(2'd0, 8'hC1, 8'hFF, 8'h00, 8'h00, 16, 1'b0, rd);
      frame(2'd0, 8'h89, 8'hEE, 8'h00, 8'h00, 16, 1'b0, rd);
      check("plan_drop_cfg", config_regs, 64'h0000_0000_005A_00A5);
      frame(2'd0, 8'h09, 8'h00, 8'h00, 8'h00, 16, 1'b0, rd);
      check("plan_read_oob", rd, 8'h00);

      // Aborted write after 12 bits, then full write.
      frame(2'd0, 8'h81, 8'h33, 8'h00, 8'h00, 12, 1'b0, rd);
      check("plan_abort_cfg", config_regs[15:8], 8'h00);
      frame(2'd0, 8'h81, 8'h77, 8'h00, 8'h00, 16, 1'b0, rd);
      check("plan_after_abort", config_regs[15:8], 8'h77);

      // Burst write starting at addr 0.
      frame(2'd0, 8'h80, 8'h11, 8'h22, 8'h33, 32, 1'b0, rd);
`ifdef SPI_REGBANK_AUTOINC_EN
      check("plan_burst", config_regs[23:0], 24'h33_22_11);
`else
      check("plan_burst", config_regs[23:0], 24'h5A_77_11);
`endif

      // Disabled clock pulse mid-frame is ignored.
      frame(2'd1, 8'h83, 8'h3C, 8'h00, 8'h00, 16, 1'b1, rd);
      check("ena_hold_write", config_regs[31:24], 8'h3C);

      // Randomized frames against the model.
      for (int n = 0; n < 40; n++) begin
         status_regs = {$urandom, $urandom};
         frame(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
               8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
               8'($urandom_range(0, 255)), nb[$urandom_range(0, 5)],
               ($urandom_range(0, 7) == 0), rd);
      end

      // Make sure the bank is non-zero, then reset in the middle of a write.
      frame(2'd0, 8'h85, 8'hC3, 8'h00, 8'h00, 16, 1'b0, rd);
      begin_frame(2'd3);
      for (int k = 0; k < 10; k++) send_bit(1'b1, k[0], mi);
      rstb = 1'b0;
      repeat (2) @(negedge clk);
      check("midreset_cfg", config_regs, 64'h0);
      check("midreset_miso", spi_miso, 1'b0);
      for (int i = 0; i < 16; i++) cfg_m[i] = 8'h00;
      spi_cs_n = 1'b1;
      repeat (2) @(negedge clk);
      rstb = 1'b1;
      repeat (3) @(negedge clk);
      cmp_cfg = 1'b1;
      frame(2'd3, 8'h86, 8'h69, 8'h00, 8'h00, 16, 1'b0, rd);
      frame(2'd0, 8'h06, 8'h00, 8'h00, 8'h00, 16, 1'b0, rd);
      check("post_reset_rb", rd, 8'h69);

      cmp_cfg = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spi_regbank_slave.md
# spi_regbank_slave

SPI slave and register bank sitting between the synchronized SPI pins and the ALU datapath. Decodes 16-bit command/data frames in all four SPI modes. Writes drive the flat `config_regs` bus that configures the ALU operands, function select and 7-seg mux. Reads return either `config_regs` or the `status_regs` bus that carries ALU results, flags and ID bytes. All SPI inputs arrive already 2-stage synchronized; the block oversamples them with `clk`.

## Interface
Parameters:
- NUM_CFG, 8, number of config registers (1..16)
- NUM_STATUS, 8, number of status registers (1..16)
- REG_WIDTH, 8, register width; must be 8, because the frame is byte-oriented

Ports:
- clk  in  1  system clock; the only clock
- rstb  in  1  reset; asynchronous, active-low
- ena  in  1  enable; when low, all state is held and edges are ignored
- mode  in  2  {CPOL, CPHA}, synchronized
- spi_cs_n  in  1  chip select, active-low, synchronized
- spi_clk  in  1  SPI clock, synchronized
- spi_mosi  in  1  master out, synchronized
- spi_miso  out  1  slave out, registered
- config_regs  out  NUM_CFG*REG_WIDTH  register n occupies bits [8n+7:8n]
- status_regs  in  NUM_STATUS*REG_WIDTH  register n occupies bits [8n+7:8n]

## Operation
- Edge detect:
  - Register `spi_clk` once as `clk_d`.
  - A rising edge is `spi_clk & ~clk_d`; a falling edge is the inverse.
  - Edges are ignored while `spi_cs_n` is high.
- Edge roles:
  - The sample edge is rising when CPOL==CPHA, otherwise falling.
  - The shift edge is the opposite edge.
  - `mode` is read on every edge, so the host may change it only while CS is high.
- Frame format, MSB first, 16 bits:
  - Byte 1 is the command: [7] write=1/read=0, [6] space (0=config, 1=status), [5:4] ignored, [3:0] address.
  - Byte 2 is data: MOSI carries write data, MISO carries read data.
- Bit counter: 5 bits, cleared while CS is high, incremented on each sample edge, saturating at 16.
- After the 8th sample edge:
  - Latch the command.
  - Load `tx_shift` with the addressed register, or 0x00 if the address is at or beyond NUM_CFG/NUM_STATUS.
  - Skip the first shift edge after the load. On every later shift edge, `tx_shift` shifts left with zero fill.
- MISO: `spi_miso = tx_shift[7]` while CS is low and the data phase is active; otherwise 0.
- Write commit, on the 16th sample edge:
  - If write=1, space=0 and addr<NUM_CFG, the received byte goes to `config_regs[addr]`.
  - A write to status space or an out-of-range address is dropped silently.
- After 16 bits, further sample edges are ignored until CS rises.
- CS rising mid-frame aborts the frame: counter cleared, no write, `tx_shift` cleared.
- Reset values: `config_regs` all 0; `spi_miso` 0; counter, command and shift registers all 0.

## Timing
- The edge is visible one `clk` after the synchronized `spi_clk` toggles.
- `config_regs` updates 1 `clk` after the 16th sample edge is detected.
- The new MISO bit is valid 1 `clk` after the shift-edge detect.
- `spi_clk` period must be at least 8 `clk` periods, with high and low phases of at least 4 `clk` each.
- CS must stay high for at least 2 `clk` between frames.
- Reset asserted mid-frame clears everything at once; the first frame after release starts cleanly when CS falls.

## Configuration
- Macro: SPI_REGBANK_AUTOINC_EN.
- With the macro defined (burst mode):
  - After each data byte, the address increments modulo 16 and the counter rewinds to the start of the data phase.
  - Reads reload `tx_shift` from the next address; writes commit every 8 sample edges.
  - The burst continues until CS rises.
- Without the macro, each frame is exactly 16 bits and extra bits are ignored with MISO held at 0.

## Test plan
- Mode 0, write 0x5A to config addr 2 (cmd 0x82) -> `config_regs[23:16]`=0x5A, all other bytes 0.
- Mode 3, `status_regs[39:32]`=0xC4, read cmd 0x44 -> MISO shifts 0xC4 on bits 9-16; `config_regs` unchanged.
- Modes 1 and 2, write 0xA5 to addr 0 (cmd 0x80), then read back with cmd 0x00 -> 0xA5 returned in both modes.
- Write cmd 0xC1 with data 0xFF (status space), and a write to addr 9 with NUM_CFG=8 -> no change to `config_regs`; a read of addr 9 returns 0x00.
- CS raised after 12 bits of write 0x81/0x33, then a full write 0x81/0x77 -> `config_regs[15:8]`=0x77, and 0x33 is never seen.
- With SPI_REGBANK_AUTOINC_EN, burst write cmd 0x80 followed by 0x11, 0x22, 0x33 -> regs 0..2 = 0x11/0x22/0x33. Without the macro, only reg 0 = 0x11.
